// File: rtl/breath_led_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : breath_led_multi                                             |
// | Description : Multi-channel "breathing" LED driver. A prescaler and a PWM  |
// |               period counter pace a triangle-wave breath position. Each    |
// |               channel derives a PWM duty from it. Modes: OFF, BREATH,      |
// |               BLINK, ON.                                                   |
// |               Optional macro BREATH_STAGGER_EN: when defined, channel i    |
// |               is offset by i*PHASE_STEP steps along the breath; when       |
// |               undefined, all channels run in lockstep with no adders.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module breath_led_multi #(
  parameter int CH_NUM         = 6,
  parameter int CNT_2US_MAX    = 50,
  parameter int CNT_2MS_MAX    = 1000,
  parameter int CNT_2S_MAX     = 1000,
  parameter int PHASE_STEP     = 0,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              hold,
  input  logic [CH_NUM-1:0] ch_en,
  output logic [CH_NUM-1:0] led,
  output logic              cycle_done
);

  // Counter widths; a single-cycle prescaler still needs one bit of storage.
  localparam int US_W  = (CNT_2US_MAX > 1) ? $clog2(CNT_2US_MAX) : 1;
  localparam int MS_W  = $clog2(CNT_2MS_MAX);
  localparam int POS_W = $clog2(2 * CNT_2S_MAX);
  localparam int CMP_W = (MS_W > POS_W) ? MS_W : POS_W;

  localparam logic [US_W-1:0]  c_US_LAST  = US_W'(CNT_2US_MAX - 1);
  localparam logic [MS_W-1:0]  c_MS_LAST  = MS_W'(CNT_2MS_MAX - 1);
  localparam logic [POS_W-1:0] c_POS_LAST = POS_W'(2 * CNT_2S_MAX - 1);
  localparam logic [POS_W-1:0] c_HALF     = POS_W'(CNT_2S_MAX);
  localparam logic             c_ACT_LOW  = (LED_ACTIVE_LOW != 0);

  // Operating modes held in the period-synchronous mode register.
  localparam logic [1:0] c_MODE_OFF    = 2'b00;
  localparam logic [1:0] c_MODE_BREATH = 2'b01;
  localparam logic [1:0] c_MODE_BLINK  = 2'b10;
  localparam logic [1:0] c_MODE_ON     = 2'b11;

  logic [US_W-1:0]   cnt_us_q, cnt_us_d;
  logic [MS_W-1:0]   cnt_ms_q, cnt_ms_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [1:0]        mode_q, mode_d;
  logic [CH_NUM-1:0] led_q, led_d;
  logic              cycle_done_q, cycle_done_d;

  logic              w_tick_us;
  logic              w_tick_ms;
  logic              w_pos_last;
  logic              w_advance;
  logic [CH_NUM-1:0] w_lit;

  // Per-channel phase, duty and lit decision, all from the current counter state.
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [POS_W-1:0] w_phase;
    logic [POS_W-1:0] w_duty;
    logic             w_pwm_on;

`ifdef BREATH_STAGGER_EN
    // Offset is bounded below one full breath, so one conditional subtract wraps it.
    localparam int OFFSET = gi * PHASE_STEP;
    logic [POS_W:0] w_sum;
    assign w_sum   = {1'b0, pos_q} + (POS_W + 1)'(OFFSET);
    assign w_phase = (w_sum >= (POS_W + 1)'(2 * CNT_2S_MAX))
                     ? POS_W'(w_sum - (POS_W + 1)'(2 * CNT_2S_MAX))
                     : w_sum[POS_W-1:0];
`else
    assign w_phase = pos_q;
`endif

    // Triangle: rising half uses the phase directly, falling half mirrors it.
    assign w_duty   = (w_phase < c_HALF) ? w_phase : (c_POS_LAST - w_phase);
    assign w_pwm_on = (CMP_W'(cnt_ms_q) < CMP_W'(w_duty));

    assign w_lit[gi] = ch_en[gi] &
                       ((mode_q == c_MODE_ON) |
                        ((mode_q == c_MODE_BREATH) & w_pwm_on) |
                        ((mode_q == c_MODE_BLINK) & (w_phase < c_HALF)));
  end

  // Next-state logic for counters, mode register, LED drive and wrap pulse.
  always_comb begin
    w_tick_us  = (cnt_us_q == c_US_LAST);
    w_tick_ms  = w_tick_us && (cnt_ms_q == c_MS_LAST);
    w_pos_last = (pos_q == c_POS_LAST);
    // Hold beats a coincident period boundary: position simply does not move.
    w_advance  = w_tick_ms && !hold;

    cnt_us_d = w_tick_us ? '0 : cnt_us_q + 1'b1;

    cnt_ms_d = cnt_ms_q;
    if (w_tick_us) begin
      cnt_ms_d = w_tick_ms ? '0 : cnt_ms_q + 1'b1;
    end

    pos_d = pos_q;
    if (w_advance) begin
      pos_d = w_pos_last ? '0 : pos_q + 1'b1;
    end

    // Mode only changes on a PWM period boundary so no period is cut short.
    mode_d       = w_tick_ms ? mode : mode_q;
    cycle_done_d = w_advance && w_pos_last;
    led_d        = w_lit ^ {CH_NUM{c_ACT_LOW}};
  end

  // State registers with synchronous reset to the idle, unlit state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_us_q     <= '0;
      cnt_ms_q     <= '0;
      pos_q        <= '0;
      mode_q       <= c_MODE_OFF;
      led_q        <= {CH_NUM{c_ACT_LOW}};
      cycle_done_q <= 1'b0;
    end else begin
      cnt_us_q     <= cnt_us_d;
      cnt_ms_q     <= cnt_ms_d;
      pos_q        <= pos_d;
      mode_q       <= mode_d;
      led_q        <= led_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign led        = led_q;
  assign cycle_done = cycle_done_q;

endmodule
`default_nettype wire

// File: doc/breath_led_multi.md
BREATH_LED_MULTI -- requirements
Module: breath_led_multi

Interface
REQ-001 Parameter CH_NUM, 6: number of LED channels, 1..32.
REQ-002 Parameter CNT_2US_MAX, 50: prescaler length in clk cycles, >=1.
REQ-003 Parameter CNT_2MS_MAX, 1000: PWM period in prescaler ticks, >=2.
REQ-004 Parameter CNT_2S_MAX, 1000: duty steps per half-breath, 2..CNT_2MS_MAX.
REQ-005 Parameter PHASE_STEP, 0: per-channel phase offset in steps; (CH_NUM-1)*PHASE_STEP < 2*CNT_2S_MAX.
REQ-006 Parameter LED_ACTIVE_LOW, 1: 1 = led bit low means lit.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 mode  input  2  00 OFF, 01 BREATH, 10 BLINK, 11 ON.
REQ-010 hold  input  1  freezes breath position while high.
REQ-011 ch_en  input  CH_NUM  per-channel enable; disabled channel is unlit.
REQ-012 led  output  CH_NUM  registered LED drive.
REQ-013 cycle_done  output  1  one-clk pulse when breath position wraps.

Function
REQ-014 Prescaler cnt_us counts 0..CNT_2US_MAX-1 and wraps; tick_us = (cnt_us == CNT_2US_MAX-1).
REQ-015 cnt_ms advances on tick_us, counts 0..CNT_2MS_MAX-1 and wraps; tick_ms = tick_us and cnt_ms at max.
REQ-016 Breath position pos counts 0..2*CNT_2S_MAX-1, advances on tick_ms when hold low, wraps to 0.
REQ-017 hold high: pos frozen; cnt_us, cnt_ms keep running, so PWM continues at frozen duty.
REQ-018 Channel phase p_i = pos + i*PHASE_STEP, minus 2*CNT_2S_MAX if >= 2*CNT_2S_MAX (single conditional subtract).
REQ-019 Duty d_i = p_i if p_i < CNT_2S_MAX, else 2*CNT_2S_MAX-1-p_i (triangle, 0..CNT_2S_MAX-1).
REQ-020 Lit condition per mode: OFF never; BREATH cnt_ms < d_i; BLINK p_i < CNT_2S_MAX; ON always; all ANDed with ch_en[i].
REQ-021 mode sampled into internal register only on tick_ms (PWM period boundary); no glitch mid-period.
REQ-022 ch_en applied immediately (combinational into led register).
REQ-023 led[i] = lit XOR LED_ACTIVE_LOW, registered; 1 clk latency from counter state.
REQ-024 cycle_done pulses exactly one clk when pos wraps 2*CNT_2S_MAX-1 -> 0; never while hold high.
REQ-025 d_i = 0 gives zero lit cycles per period; d_i = CNT_2S_MAX-1 gives CNT_2S_MAX-1 prescaler ticks lit.
REQ-026 Simultaneous hold rise and tick_ms: hold wins, pos not advanced.

Reset
REQ-027 While reset high at clk edge: cnt_us, cnt_ms, pos = 0; registered mode = OFF; cycle_done = 0.
REQ-028 led reset value all channels unlit ({CH_NUM{LED_ACTIVE_LOW}}).
REQ-029 Reset mid-operation aborts current period/breath; first cycle after release starts at pos 0, cnt_ms 0.
REQ-030 Mode input becomes effective at first tick_ms after reset release.

Configuration
REQ-031 Macro BREATH_STAGGER_EN defined: phase offset per REQ-018 active.
REQ-032 BREATH_STAGGER_EN undefined: p_i = pos for all channels (PHASE_STEP ignored, no adder logic), all channels in lockstep.

Verification
Bench parameters: CH_NUM=2, CNT_2US_MAX=2, CNT_2MS_MAX=4, CNT_2S_MAX=4, PHASE_STEP=4, LED_ACTIVE_LOW=1; PWM period 8 clk, full breath 64 clk.
REQ-033 Reset held 10 clk, mode=01, ch_en=11 -> led=2'b11 throughout reset and first period; cycle_done low.
REQ-034 Release reset, mode=01 -> cycle_done first pulses 64 clk after release, then every 64 clk, width 1 clk.
REQ-035 BREATH, pos=2, stagger off -> led[0] low for 4 of each 8 clk; pos=3 -> 6 of 8; pos=4 -> 6 of 8; pos=7 -> 0 of 8.
REQ-036 Stagger on, pos=0 -> ch0 duty 0 (led[0] stays 1), ch1 p=4 duty 3 (led[1] low 6 of 8 clk).
REQ-037 hold high for 100 clk at pos=3 -> duty stays 3, no cycle_done; release -> pos resumes 3->4 at next tick_ms.
REQ-038 mode 01->11 mid-period -> led unchanged until period boundary, then led=2'b00; ch_en=01 -> led=2'b10 next clk.
